// File: rtl/aibcr3_dll_code_ctrl_if.sv
// Signal bundle between the DLL code controller and the alignment datapath.
interface aibcr3_dll_code_ctrl_if;
  logic        lock_req;
  logic        t_up;
  logic        t_down;
  logic [10:0] csr_init_code;
  logic [7:0]  f_gray;
  logic [2:0]  i_gray;
  logic        code_valid;
  logic        dll_lock;
  logic        dll_phdet_reset_n;
  logic        sat_err;

  modport master (
    output lock_req, t_up, t_down, csr_init_code,
    input  f_gray, i_gray, code_valid, dll_lock, dll_phdet_reset_n, sat_err
  );

  modport slave (
    input  lock_req, t_up, t_down, csr_init_code,
    output f_gray, i_gray, code_valid, dll_lock, dll_phdet_reset_n, sat_err
  );
endinterface

// File: rtl/aibcr3_dll_code_ctrl.sv
// DLL delay-code stepping controller: phase-detector driven Gray coarse/fine codes.
// Optional macro AIBCR3_DLL_CODE_CTRL_PHD_SYNC_EN adds a 2-flop synchronizer on t_up/t_down.
module aibcr3_dll_code_ctrl #(
  parameter int SETTLE     = 8,
  parameter int LOCK_FLIPS = 4,
  parameter int CODE_MAX   = 511
) (
  input  logic                     clk_pll,
  input  logic                     str_rst_n,
  aibcr3_dll_code_ctrl_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, PHRST, SEARCH, TRACK} state_t;

  localparam logic [10:0] CMAX  = 11'(CODE_MAX);
  localparam logic [7:0]  WLAST = 8'(SETTLE - 1);
  localparam logic [3:0]  LFLIP = 4'(LOCK_FLIPS);

  state_t      state, state_n;
  logic [1:0]  pcnt, pcnt_n;
  logic [7:0]  wcnt, wcnt_n;
  logic [10:0] code, code_n;
  logic [3:0]  rev, rev_n;
  logic        last_up, last_up_n;
  logic        have_dir, have_dir_n;
  logic [2:0]  satcnt, satcnt_n;
  logic        sat_err_n;
  logic        up_s, dn_s;
  logic        step_up, step_dn, decide, sat_hit, active_n;
  logic [10:0] init_code;

`ifdef AIBCR3_DLL_CODE_CTRL_PHD_SYNC_EN
  logic [1:0] up_pipe, dn_pipe;
  always_ff @(posedge clk_pll or negedge str_rst_n) begin
    if (!str_rst_n) begin
      up_pipe <= '0;
      dn_pipe <= '0;
    end else begin
      up_pipe <= {up_pipe[0], bus.t_up};
      dn_pipe <= {dn_pipe[0], bus.t_down};
    end
  end
  assign up_s = up_pipe[1];
  assign dn_s = dn_pipe[1];
`else
  assign up_s = bus.t_up;
  assign dn_s = bus.t_down;
`endif

  assign init_code = (bus.csr_init_code > CMAX) ? CMAX : bus.csr_init_code;
  assign step_up   = up_s & ~dn_s;
  assign step_dn   = dn_s & ~up_s;
  assign decide    = (wcnt == WLAST);

  always_comb begin
    state_n    = state;
    pcnt_n     = pcnt;
    wcnt_n     = wcnt;
    code_n     = code;
    rev_n      = rev;
    last_up_n  = last_up;
    have_dir_n = have_dir;
    satcnt_n   = satcnt;
    sat_err_n  = bus.sat_err;
    sat_hit    = 1'b0;
    case (state)
      IDLE: begin
        code_n     = init_code;
        pcnt_n     = '0;
        wcnt_n     = '0;
        rev_n      = '0;
        last_up_n  = 1'b0;
        have_dir_n = 1'b0;
        satcnt_n   = '0;
        sat_err_n  = 1'b0;
        if (bus.lock_req) state_n = PHRST;
      end
      PHRST: begin
        pcnt_n = pcnt + 2'd1;
        if (pcnt == 2'd3) state_n = SEARCH;
      end
      default: begin
        if (state == SEARCH && rev == LFLIP) state_n = TRACK;
        wcnt_n = decide ? 8'd0 : wcnt + 8'd1;
        if (decide) begin
          sat_hit = (step_up && code == CMAX) || (step_dn && code == 11'd0);
          if (sat_hit) begin
            // saturated decisions leave code and reversal history untouched
            if (satcnt != 3'd4) satcnt_n = satcnt + 3'd1;
            if (satcnt >= 3'd3) sat_err_n = 1'b1;
          end else begin
            satcnt_n = '0;
            if (step_up || step_dn) begin
              code_n     = step_up ? code + 11'd1 : code - 11'd1;
              rev_n      = (have_dir && last_up != step_up) ? rev + 4'd1 : 4'd0;
              last_up_n  = step_up;
              have_dir_n = 1'b1;
            end
          end
        end
      end
    endcase
    // abort overrides the window position
    if (state != IDLE && !bus.lock_req) begin
      state_n    = IDLE;
      code_n     = init_code;
      pcnt_n     = '0;
      wcnt_n     = '0;
      rev_n      = '0;
      last_up_n  = 1'b0;
      have_dir_n = 1'b0;
      satcnt_n   = '0;
      sat_err_n  = 1'b0;
    end
  end

  assign active_n = (state_n == SEARCH) || (state_n == TRACK);

  always_ff @(posedge clk_pll or negedge str_rst_n) begin
    if (!str_rst_n) begin
      state                 <= IDLE;
      pcnt                  <= '0;
      wcnt                  <= '0;
      code                  <= '0;
      rev                   <= '0;
      last_up               <= 1'b0;
      have_dir              <= 1'b0;
      satcnt                <= '0;
      bus.sat_err           <= 1'b0;
      bus.f_gray            <= '0;
      bus.i_gray            <= '0;
      bus.code_valid        <= 1'b0;
      bus.dll_lock          <= 1'b0;
      bus.dll_phdet_reset_n <= 1'b0;
    end else begin
      state                 <= state_n;
      pcnt                  <= pcnt_n;
      wcnt                  <= wcnt_n;
      code                  <= code_n;
      rev                   <= rev_n;
      last_up               <= last_up_n;
      have_dir              <= have_dir_n;
      satcnt                <= satcnt_n;
      bus.sat_err           <= sat_err_n;
      bus.f_gray            <= code_n[10:3] ^ (code_n[10:3] >> 1);
      bus.i_gray            <= code_n[2:0] ^ (code_n[2:0] >> 1);
      bus.code_valid        <= active_n && (wcnt_n >= 8'd2);
      bus.dll_lock          <= (state_n == TRACK);
      bus.dll_phdet_reset_n <= active_n;
    end
  end
endmodule

// File: tb/tb_aibcr3_dll_code_ctrl.sv
// Bench for aibcr3_dll_code_ctrl: vector table, directed corner sequences, randomized model check.
module tb_aibcr3_dll_code_ctrl;
  localparam int SETTLE = 8, LOCK_FLIPS = 4, CODE_MAX = 511;
`ifdef AIBCR3_DLL_CODE_CTRL_PHD_SYNC_EN
  localparam int DLY = 2;
`else
  localparam int DLY = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aibcr3_dll_code_ctrl_if bus();
  aibcr3_dll_code_ctrl #(.SETTLE(SETTLE), .LOCK_FLIPS(LOCK_FLIPS), .CODE_MAX(CODE_MAX))
    dut (.clk_pll(clk), .str_rst_n(rst_n), .bus(bus));

  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [10:0] gray_of(input int c);
    logic [10:0] b;
    b = 11'(c);
    return {b[10:3] ^ (b[10:3] >> 1), b[2:0] ^ (b[2:0] >> 1)};
  endfunction

  // reference model: mode 0 idle, 1 phase-detector reset, 2 search, 3 track
  int m_mode, m_ph, m_ts, m_code, m_rev, m_dir, m_satn;
  bit m_sat, m_u1, m_u2, m_d1, m_d2;

  task automatic model_reset();
    m_mode = 0; m_ph = 0; m_ts = 0; m_code = 0; m_rev = 0; m_dir = 0; m_satn = 0;
    m_sat = 0; m_u1 = 0; m_u2 = 0; m_d1 = 0; m_d2 = 0;
  endtask

  task automatic model_edge();
    bit u, d;
    int init, s;
    u = (DLY == 2) ? m_u2 : bus.t_up;
    d = (DLY == 2) ? m_d2 : bus.t_down;
    m_u2 = m_u1; m_u1 = bus.t_up;
    m_d2 = m_d1; m_d1 = bus.t_down;
    init = (int'(bus.csr_init_code) > CODE_MAX) ? CODE_MAX : int'(bus.csr_init_code);
    if (m_mode != 0 && !bus.lock_req) begin
      m_mode = 0; m_code = init; m_rev = 0; m_dir = 0; m_satn = 0; m_sat = 0;
    end else if (m_mode == 0) begin
      m_code = init; m_rev = 0; m_dir = 0; m_satn = 0; m_sat = 0;
      if (bus.lock_req) begin m_mode = 1; m_ph = 0; end
    end else if (m_mode == 1) begin
      m_ph++;
      if (m_ph == 4) begin m_mode = 2; m_ts = 0; end
    end else begin
      if (m_mode == 2 && m_rev == LOCK_FLIPS) m_mode = 3;
      if (m_ts % SETTLE == SETTLE - 1) begin
        s = (u && !d) ? 1 : (d && !u) ? -1 : 0;
        if (s != 0 && (m_code + s < 0 || m_code + s > CODE_MAX)) begin
          m_satn++;
          if (m_satn >= 4) m_sat = 1;
        end else begin
          m_satn = 0;
          if (s != 0) begin
            m_rev = (m_dir != 0 && m_dir != s) ? (m_rev + 1) % 16 : 0;
            m_dir = s;
            m_code += s;
          end
        end
      end
      m_ts++;
    end
  endtask

  function automatic logic [15:0] model_out();
    bit act;
    act = (m_mode >= 2);
    return {gray_of(m_code), act && (m_ts % SETTLE >= 2), m_mode == 3, act, m_sat};
  endfunction

  function automatic logic [15:0] dut_out();
    return {bus.f_gray, bus.i_gray, bus.code_valid, bus.dll_lock, bus.dll_phdet_reset_n, bus.sat_err};
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.lock_req = 1'b0;
    model_reset();
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    string nm;
    int    init, windows, exp_code;
    bit    up, dn, exp_lock, exp_sat;
  } vec_t;

  vec_t vecs[7];

  initial begin
    bus.lock_req = 0; bus.t_up = 0; bus.t_down = 0; bus.csr_init_code = 0;
    model_reset();

    vecs[0] = '{"step_up",   100,  5, 105, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{"step_dn",    50,  3,  47, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{"sat_pre",     2,  5,   0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{"sat_set",     2,  6,   0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{"clamp",    2047,  0, 511, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{"hold_both",  300, 10, 300, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{"sat_top",   510,  6, 511, 1'b1, 1'b0, 1'b0, 1'b1};

    // table: outputs sampled just after the last window boundary
    foreach (vecs[k]) begin
      do_reset();
      bus.csr_init_code = 11'(vecs[k].init);
      bus.t_up = vecs[k].up;
      bus.t_down = vecs[k].dn;
      cyc(); cyc();
      check({vecs[k].nm, "_idle_phd"}, 32'(bus.dll_phdet_reset_n), 32'd0);
      bus.lock_req = 1'b1;
      repeat (5 + SETTLE * vecs[k].windows) cyc();
      check({vecs[k].nm, "_gray"}, 32'({bus.f_gray, bus.i_gray}), 32'(gray_of(vecs[k].exp_code)));
      check({vecs[k].nm, "_lock"}, 32'(bus.dll_lock), 32'(vecs[k].exp_lock));
      check({vecs[k].nm, "_sat"},  32'(bus.sat_err), 32'(vecs[k].exp_sat));
      check({vecs[k].nm, "_cv"},   32'(bus.code_valid), 32'd0);
      check({vecs[k].nm, "_phd"},  32'(bus.dll_phdet_reset_n), 32'd1);
    end
    check("step_up_f_gray", 32'(gray_of(105) >> 3), 32'h0B);

    // async reset mid-window, release with lock_req low
    do_reset();
    bus.csr_init_code = 11'd77; bus.t_up = 1; bus.t_down = 0; bus.lock_req = 1;
    repeat (20) cyc();
    #2 rst_n = 1'b0;
    model_reset();
    #1 check("rst_outputs", 32'(dut_out()), 32'd0);
    bus.lock_req = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    repeat (3) cyc();
    check("rst_phd_low", 32'(bus.dll_phdet_reset_n), 32'd0);
    check("rst_init_load", 32'({bus.f_gray, bus.i_gray}), 32'(gray_of(77)));

    // lock by alternating direction, then abort from TRACK
    do_reset();
    bus.csr_init_code = 11'd200; bus.t_up = 1; bus.t_down = 0;
    bus.lock_req = 1;
    repeat (5) cyc();
    for (int w = 1; w <= 5; w++) begin
      bus.t_up = (w % 2 == 1);
      bus.t_down = !bus.t_up;
      for (int k = 0; k < SETTLE; k++) begin
        cyc();
        if (w == 2 && k == 0) check("cv_low_wcnt1", 32'(bus.code_valid), 32'd0);
        if (w == 2 && k == 1) check("cv_high_wcnt2", 32'(bus.code_valid), 32'd1);
      end
      if (w == 1) check("cv_low_boundary", 32'(bus.code_valid), 32'd0);
      check($sformatf("dither_w%0d", w), 32'({bus.f_gray, bus.i_gray}),
            32'(gray_of((w % 2 == 1) ? 201 : 200)));
    end
    check("lock_not_yet", 32'(bus.dll_lock), 32'd0);
    cyc();
    check("lock_rise", 32'(bus.dll_lock), 32'd1);
    bus.lock_req = 1'b0;
    cyc();
    check("abort_flags", 32'({bus.dll_lock, bus.code_valid, bus.dll_phdet_reset_n}), 32'd0);
    check("abort_reload", 32'({bus.f_gray, bus.i_gray}), 32'(gray_of(200)));

    // randomized run against the model
    do_reset();
    bus.lock_req = 0;
    begin
      int bias = 0;
      for (int c = 0; c < 4000; c++) begin
        if (c % 64 == 0) bias = $urandom_range(0, 3);
        if (m_mode == 0) begin
          if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 5))
              0: bus.csr_init_code = 11'd0;
              1: bus.csr_init_code = 11'd1;
              2: bus.csr_init_code = 11'd510;
              3: bus.csr_init_code = 11'd2047;
              default: bus.csr_init_code = 11'($urandom);
            endcase
          end
          bus.lock_req = ($urandom_range(0, 3) == 0);
        end else begin
          bus.lock_req = ($urandom_range(0, 299) != 0);
        end
        case (bias)
          1: begin bus.t_up = ($urandom_range(0, 7) != 0); bus.t_down = ($urandom_range(0, 7) == 0); end
          2: begin bus.t_up = ($urandom_range(0, 7) == 0); bus.t_down = ($urandom_range(0, 7) != 0); end
          3: begin bus.t_up = ((m_ts / SETTLE) % 2 == 0); bus.t_down = !bus.t_up; end
          default: begin bus.t_up = 1'($urandom); bus.t_down = 1'($urandom); end
        endcase
        cyc();
        check($sformatf("rand_c%0d", c), 32'(dut_out()), 32'(model_out()));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
